fu_cdb_arbiter: RTL and testbench
=================================

# fu_cdb_arbiter

Parametrised writeback and CDB arbitration stage between the execution units (int ALU, branch ALU, multiplier, load unit, …) and the physical register file, ROB and RS wakeup logic. Each FU result channel feeds a private FIFO, so simultaneous completions are queued rather than dropped. A round-robin arbiter drains up to NUM_CDB results per cycle onto registered CDB ports. Flush squashes everything in flight on branch recovery.

## Interface
- NUM_FU, 4: number of FU result channels (≥2)
- NUM_CDB, 1: CDB broadcast ports per cycle (1..NUM_FU)
- DEPTH, 2: per-channel FIFO entries (power of 2, ≥2)
- DATA_W, 64: result width
- PRF_IDX_W, 6: physical tag width
- ROB_IDX_W, 5: ROB index width
- ZERO_TAG, 31: tag meaning "no destination register"

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  squash all queued and output entries
- fu_vld_i  in  NUM_FU  channel i has a result this cycle
- fu_tag_i  in  NUM_FU*PRF_IDX_W  dest tag, channel i at slice i
- fu_value_i  in  NUM_FU*DATA_W  result value
- fu_rob_idx_i  in  NUM_FU*ROB_IDX_W  ROB index
- fu_rdy_o  out  NUM_FU  channel i FIFO can accept this cycle
- cdb_vld_o  out  NUM_CDB  port valid (ROB completion)
- cdb_wr_en_o  out  NUM_CDB  PRF write / RS wakeup: vld and tag≠ZERO_TAG
- cdb_tag_o  out  NUM_CDB*PRF_IDX_W  broadcast tag
- cdb_value_o  out  NUM_CDB*DATA_W  writeback value
- cdb_rob_idx_o  out  NUM_CDB*ROB_IDX_W  ROB index
- overflow_o  out  1  sticky: push attempted while full

## Operation
- Per channel: FIFO with head/tail pointers wrapping mod DEPTH and count 0..DEPTH.
- fu_rdy_o[i] = (count[i] < DEPTH) and not rst; based on registered count only, no credit for a same-cycle pop.
- Push: fu_vld_i[i] and fu_rdy_o[i] and not flush_i. fu_vld_i[i] while not ready: entry dropped, overflow_o set to 1 until reset.
- Arbitration (combinational on FIFO heads): scan channels from rr_ptr upward, mod NUM_FU. The first NUM_CDB non-empty channels each get one grant. At most one pop per channel per cycle.
- The k-th grant in scan order drives CDB port k. Unused ports are vld=0, tag=ZERO_TAG, value=0, rob_idx=0.
- rr_ptr next value = (last granted index + 1) mod NUM_FU. Unchanged if nothing was granted.
- Push and pop on the same channel in the same cycle: count unchanged, FIFO order preserved.
- A ZERO_TAG entry still broadcasts with cdb_vld_o=1 (ROB completion) and cdb_wr_en_o=0.
- flush_i: at the next edge all counts and pointers go to 0 and all cdb_vld_o go to 0. Same-cycle pushes and grants are discarded. rr_ptr and overflow_o are kept.

## Timing
- Reset values: cdb_vld_o=0, cdb_wr_en_o=0, cdb_tag_o=ZERO_TAG, cdb_value_o=0, cdb_rob_idx_o=0, overflow_o=0, rr_ptr=0, all FIFOs empty. fu_rdy_o=0 while rst=1, and all 1s in the first cycle after rst is released.
- Latency: a result pushed at edge E0 appears on the CDB after edge E1 (one cycle later), provided it wins arbitration.
- All cdb_* outputs are registered and held for exactly one cycle per grant.
- Throughput: NUM_CDB results per cycle. A single-channel stream sustains 1 result per cycle.
- rst asserted mid-operation: identical to power-up reset at that edge; queued entries are lost.

## Test plan
- Single result: NUM_FU=4, NUM_CDB=1. Channel 0 pushes tag=5, value=0x1234, rob=3 at E0 -> after E1, cdb_vld=1, wr_en=1, tag=5, value=0x1234, rob=3; after E2, vld=0.
- Collision fairness: channels 0–3 all push at E0 with rr_ptr=0 -> broadcasts in order ch0, ch1, ch2, ch3 on consecutive cycles. The next collision starts from ch0 only after rr_ptr wraps; verify rr_ptr=0 after the ch3 grant.
- Full/overflow: DEPTH=2. Channel 1 pushes every cycle while another channel holds the CDB -> fu_rdy_o[1]=0 after 2 pushes. A third push sets overflow_o=1 and that entry never appears on the CDB.
- Dual CDB: NUM_CDB=2, channels 1 and 3 push tags 7 and 9 at E0 -> after E1, port0 tag=7 and port1 tag=9 together; rr_ptr=0.
- ZERO_TAG: channel 2 pushes tag=31 (branch) -> cdb_vld_o=1 and cdb_wr_en_o=0.
- Flush: 3 entries queued, flush_i=1 together with a new push -> after that edge, all cdb_vld_o=0 and all counts=0; nothing from before the flush is ever broadcast.

Source files
------------

// File: rtl/fu_cdb_if.sv
`default_nettype none
// ============================================================================
// Module   : fu_cdb_if
// Brief    : FU result channels in, CDB broadcast ports out, plus flush and
//            sticky overflow for the writeback / CDB arbitration stage.
// Revision : 1.0 - initial release
// ============================================================================
interface fu_cdb_if #(
  parameter int NUM_FU    = 4,
  parameter int NUM_CDB   = 1,
  parameter int DATA_W    = 64,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5
);
  logic                           flush_i;
  logic [NUM_FU-1:0]              fu_vld_i;
  logic [NUM_FU*PRF_IDX_W-1:0]    fu_tag_i;
  logic [NUM_FU*DATA_W-1:0]       fu_value_i;
  logic [NUM_FU*ROB_IDX_W-1:0]    fu_rob_idx_i;
  logic [NUM_FU-1:0]              fu_rdy_o;
  logic [NUM_CDB-1:0]             cdb_vld_o;
  logic [NUM_CDB-1:0]             cdb_wr_en_o;
  logic [NUM_CDB*PRF_IDX_W-1:0]   cdb_tag_o;
  logic [NUM_CDB*DATA_W-1:0]      cdb_value_o;
  logic [NUM_CDB*ROB_IDX_W-1:0]   cdb_rob_idx_o;
  logic                           overflow_o;

  // Execution units / recovery logic side
  modport master (
    output flush_i, fu_vld_i, fu_tag_i, fu_value_i, fu_rob_idx_i,
    input  fu_rdy_o, cdb_vld_o, cdb_wr_en_o, cdb_tag_o, cdb_value_o,
           cdb_rob_idx_o, overflow_o
  );

  // Arbitration stage side
  modport slave (
    input  flush_i, fu_vld_i, fu_tag_i, fu_value_i, fu_rob_idx_i,
    output fu_rdy_o, cdb_vld_o, cdb_wr_en_o, cdb_tag_o, cdb_value_o,
           cdb_rob_idx_o, overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/fu_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fu_cdb_arbiter
// Brief    : Per-FU result FIFOs drained by a round-robin arbiter onto
//            NUM_CDB registered CDB ports; flush squashes everything queued.
// Revision : 1.0 - initial release
// ============================================================================
module fu_cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int NUM_CDB   = 1,
  parameter int DEPTH     = 2,
  parameter int DATA_W    = 64,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int ZERO_TAG  = 31
) (
  input  logic    clk,
  input  logic    rst,
  fu_cdb_if.slave bus
);
  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = $clog2(DEPTH + 1);
  localparam int C_RR_W  = $clog2(NUM_FU);
  localparam logic [PRF_IDX_W-1:0] C_ZERO_TAG = PRF_IDX_W'(ZERO_TAG);

  logic [PRF_IDX_W-1:0] r_tag_mem [NUM_FU][DEPTH];
  logic [DATA_W-1:0]    r_val_mem [NUM_FU][DEPTH];
  logic [ROB_IDX_W-1:0] r_rob_mem [NUM_FU][DEPTH];
  logic [C_PTR_W-1:0]   r_head    [NUM_FU];
  logic [C_PTR_W-1:0]   r_tail    [NUM_FU];
  logic [C_CNT_W-1:0]   r_count   [NUM_FU];
  logic [C_RR_W-1:0]    r_rr;
  logic                 r_overflow;

  logic                 r_cdb_vld   [NUM_CDB];
  logic                 r_cdb_wr_en [NUM_CDB];
  logic [PRF_IDX_W-1:0] r_cdb_tag   [NUM_CDB];
  logic [DATA_W-1:0]    r_cdb_val   [NUM_CDB];
  logic [ROB_IDX_W-1:0] r_cdb_rob   [NUM_CDB];

  logic [NUM_FU-1:0]    w_rdy;
  logic [NUM_FU-1:0]    w_push;
  logic [NUM_FU-1:0]    w_grant;
  logic [C_RR_W-1:0]    w_nxt_rr;
  logic                 w_port_vld  [NUM_CDB];
  logic [PRF_IDX_W-1:0] w_port_tag  [NUM_CDB];
  logic [DATA_W-1:0]    w_port_val  [NUM_CDB];
  logic [ROB_IDX_W-1:0] w_port_rob  [NUM_CDB];
  logic                 w_drop;

  // Ready is based on the registered count only; a push needs ready and no flush
  always_comb begin
    w_rdy  = '0;
    w_push = '0;
    w_drop = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_rdy[i]  = (r_count[i] < C_CNT_W'(DEPTH)) && !rst;
      w_push[i] = bus.fu_vld_i[i] && w_rdy[i] && !bus.flush_i;
      if (bus.fu_vld_i[i] && !w_rdy[i]) w_drop = 1'b1;
    end
  end

  // Round-robin scan from r_rr: the first NUM_CDB non-empty heads win, in scan order
  always_comb begin
    int n;
    int idx_int;
    logic [C_RR_W-1:0] idx;
    w_grant  = '0;
    w_nxt_rr = r_rr;
    n        = 0;
    for (int p = 0; p < NUM_CDB; p++) begin
      w_port_vld[p] = 1'b0;
      w_port_tag[p] = C_ZERO_TAG;
      w_port_val[p] = '0;
      w_port_rob[p] = '0;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      idx_int = int'(r_rr) + k;
      if (idx_int >= NUM_FU) idx_int = idx_int - NUM_FU;
      idx = C_RR_W'(idx_int);
      if ((n < NUM_CDB) && (r_count[idx] != '0)) begin
        w_grant[idx]  = 1'b1;
        w_port_vld[n] = 1'b1;
        w_port_tag[n] = r_tag_mem[idx][r_head[idx]];
        w_port_val[n] = r_val_mem[idx][r_head[idx]];
        w_port_rob[n] = r_rob_mem[idx][r_head[idx]];
        w_nxt_rr      = (idx_int == NUM_FU - 1) ? '0 : C_RR_W'(idx_int + 1);
        n             = n + 1;
      end
    end
  end

  // Per-channel FIFO storage, pointers and occupancy; flush empties every queue
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (rst || bus.flush_i) begin
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
      end else begin
        if (w_push[i]) begin
          r_tag_mem[i][r_tail[i]] <= bus.fu_tag_i[i*PRF_IDX_W +: PRF_IDX_W];
          r_val_mem[i][r_tail[i]] <= bus.fu_value_i[i*DATA_W +: DATA_W];
          r_rob_mem[i][r_tail[i]] <= bus.fu_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W];
          r_tail[i]               <= r_tail[i] + C_PTR_W'(1);
        end
        if (w_grant[i]) r_head[i] <= r_head[i] + C_PTR_W'(1);
        if (w_push[i] && !w_grant[i]) begin
          r_count[i] <= r_count[i] + C_CNT_W'(1);
        end else if (!w_push[i] && w_grant[i]) begin
          r_count[i] <= r_count[i] - C_CNT_W'(1);
        end
      end
    end
  end

  // Registered CDB ports: one cycle per grant, idle values otherwise
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_CDB; p++) begin
      if (rst || bus.flush_i || !w_port_vld[p]) begin
        r_cdb_vld[p]   <= 1'b0;
        r_cdb_wr_en[p] <= 1'b0;
        r_cdb_tag[p]   <= C_ZERO_TAG;
        r_cdb_val[p]   <= '0;
        r_cdb_rob[p]   <= '0;
      end else begin
        r_cdb_vld[p]   <= 1'b1;
        r_cdb_wr_en[p] <= (w_port_tag[p] != C_ZERO_TAG);
        r_cdb_tag[p]   <= w_port_tag[p];
        r_cdb_val[p]   <= w_port_val[p];
        r_cdb_rob[p]   <= w_port_rob[p];
      end
    end
  end

  // Round-robin pointer and sticky overflow both survive a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (!bus.flush_i) r_rr <= w_nxt_rr;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.fu_rdy_o   = w_rdy;
  assign bus.overflow_o = r_overflow;

  for (genvar p = 0; p < NUM_CDB; p++) begin : g_port
    assign bus.cdb_vld_o[p]                              = r_cdb_vld[p];
    assign bus.cdb_wr_en_o[p]                            = r_cdb_wr_en[p];
    assign bus.cdb_tag_o[p*PRF_IDX_W +: PRF_IDX_W]       = r_cdb_tag[p];
    assign bus.cdb_value_o[p*DATA_W +: DATA_W]           = r_cdb_val[p];
    assign bus.cdb_rob_idx_o[p*ROB_IDX_W +: ROB_IDX_W]   = r_cdb_rob[p];
  end : g_port

endmodule
`default_nettype wire

// File: tb/tb_fu_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_cdb_arbiter
// Brief    : Drives a single-CDB and a dual-CDB arbiter with the same FU
//            traffic and compares both against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fu_cdb_arbiter;
  localparam int NUM_FU    = 4;
  localparam int DEPTH     = 2;
  localparam int DATA_W    = 64;
  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
  localparam int ZERO_TAG  = 31;

  typedef struct packed {
    logic [PRF_IDX_W-1:0] tag;
    logic [DATA_W-1:0]    val;
    logic [ROB_IDX_W-1:0] rob;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fu_cdb_if #(.NUM_FU(NUM_FU), .NUM_CDB(1), .DATA_W(DATA_W),
              .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W)) bus1 ();
  fu_cdb_if #(.NUM_FU(NUM_FU), .NUM_CDB(2), .DATA_W(DATA_W),
              .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W)) bus2 ();

  fu_cdb_arbiter #(.NUM_FU(NUM_FU), .NUM_CDB(1), .DEPTH(DEPTH), .DATA_W(DATA_W),
                   .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W), .ZERO_TAG(ZERO_TAG))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fu_cdb_arbiter #(.NUM_FU(NUM_FU), .NUM_CDB(2), .DEPTH(DEPTH), .DATA_W(DATA_W),
                   .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W), .ZERO_TAG(ZERO_TAG))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // stimulus shared by both instances
  logic                 s_flush;
  logic [NUM_FU-1:0]    s_vld;
  logic [PRF_IDX_W-1:0] s_tag [NUM_FU];
  logic [DATA_W-1:0]    s_val [NUM_FU];
  logic [ROB_IDX_W-1:0] s_rob [NUM_FU];

  // reference model state, index 0 = single CDB, 1 = dual CDB
  ent_t mq [2][NUM_FU][$];
  int   rr [2];
  bit   ovf [2];
  bit   ev [2][2];
  ent_t ee [2][2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    bus1.flush_i  = s_flush;
    bus2.flush_i  = s_flush;
    bus1.fu_vld_i = s_vld;
    bus2.fu_vld_i = s_vld;
    for (int i = 0; i < NUM_FU; i++) begin
      bus1.fu_tag_i[i*PRF_IDX_W +: PRF_IDX_W]     = s_tag[i];
      bus2.fu_tag_i[i*PRF_IDX_W +: PRF_IDX_W]     = s_tag[i];
      bus1.fu_value_i[i*DATA_W +: DATA_W]         = s_val[i];
      bus2.fu_value_i[i*DATA_W +: DATA_W]         = s_val[i];
      bus1.fu_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W] = s_rob[i];
      bus2.fu_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W] = s_rob[i];
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NUM_FU; i++) mq[d][i].delete();
      rr[d]  = 0;
      ovf[d] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        ev[d][p]     = 1'b0;
        ee[d][p].tag = PRF_IDX_W'(ZERO_TAG);
        ee[d][p].val = '0;
        ee[d][p].rob = '0;
      end
    end
  endtask

  task automatic chk_port(input string who, input logic vld, input logic wr,
                          input logic [PRF_IDX_W-1:0] tag, input logic [DATA_W-1:0] val,
                          input logic [ROB_IDX_W-1:0] rob, input int d, input int p);
    chk({who, " vld"},   64'(vld), 64'(ev[d][p]));
    chk({who, " wr_en"}, 64'(wr),  64'(ev[d][p] && (ee[d][p].tag != PRF_IDX_W'(ZERO_TAG))));
    chk({who, " tag"},   64'(tag), 64'(ee[d][p].tag));
    chk({who, " value"}, val,      ee[d][p].val);
    chk({who, " rob"},   64'(rob), 64'(ee[d][p].rob));
  endtask

  task automatic check_outputs();
    logic [NUM_FU-1:0] er1;
    logic [NUM_FU-1:0] er2;
    for (int i = 0; i < NUM_FU; i++) begin
      er1[i] = !rst && (mq[0][i].size() < DEPTH);
      er2[i] = !rst && (mq[1][i].size() < DEPTH);
    end
    chk("c1 rdy", 64'(bus1.fu_rdy_o), 64'(er1));
    chk("c2 rdy", 64'(bus2.fu_rdy_o), 64'(er2));
    chk("c1 overflow", 64'(bus1.overflow_o), 64'(ovf[0]));
    chk("c2 overflow", 64'(bus2.overflow_o), 64'(ovf[1]));
    chk_port("c1 p0", bus1.cdb_vld_o[0], bus1.cdb_wr_en_o[0], bus1.cdb_tag_o,
             bus1.cdb_value_o, bus1.cdb_rob_idx_o, 0, 0);
    chk_port("c2 p0", bus2.cdb_vld_o[0], bus2.cdb_wr_en_o[0], bus2.cdb_tag_o[5:0],
             bus2.cdb_value_o[63:0], bus2.cdb_rob_idx_o[4:0], 1, 0);
    chk_port("c2 p1", bus2.cdb_vld_o[1], bus2.cdb_wr_en_o[1], bus2.cdb_tag_o[11:6],
             bus2.cdb_value_o[127:64], bus2.cdb_rob_idx_o[9:5], 1, 1);
  endtask

  // Behaviour at one clock edge, expressed as queue operations
  task automatic model_step();
    int   n;
    int   ch;
    int   nrr;
    bit   rdy [NUM_FU];
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NUM_FU; i++) rdy[i] = (mq[d][i].size() < DEPTH);
      for (int i = 0; i < NUM_FU; i++) if (s_vld[i] && !rdy[i]) ovf[d] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        ev[d][p]     = 1'b0;
        ee[d][p].tag = PRF_IDX_W'(ZERO_TAG);
        ee[d][p].val = '0;
        ee[d][p].rob = '0;
      end
      if (s_flush) begin
        for (int i = 0; i < NUM_FU; i++) mq[d][i].delete();
      end else begin
        n   = 0;
        nrr = rr[d];
        for (int k = 0; k < NUM_FU; k++) begin
          ch = (rr[d] + k) % NUM_FU;
          if (n < d + 1 && mq[d][ch].size() > 0) begin
            ee[d][n] = mq[d][ch].pop_front();
            ev[d][n] = 1'b1;
            n++;
            nrr = (ch + 1) % NUM_FU;
          end
        end
        rr[d] = nrr;
        for (int i = 0; i < NUM_FU; i++) begin
          if (s_vld[i] && rdy[i]) begin
            e.tag = s_tag[i];
            e.val = s_val[i];
            e.rob = s_rob[i];
            mq[d][i].push_back(e);
          end
        end
      end
    end
  endtask

  // Apply one cycle of inputs, compare, advance the model, pass the edge
  task automatic step(input logic r, input logic f, input logic [NUM_FU-1:0] v);
    rst     = r;
    s_flush = f;
    s_vld   = v;
    drive();
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NUM_FU; i++) begin
      s_tag[i] = ($urandom_range(0, 3) == 0) ? PRF_IDX_W'(ZERO_TAG) : PRF_IDX_W'($urandom_range(0, 63));
      s_val[i] = {$urandom, $urandom};
      s_rob[i] = ROB_IDX_W'($urandom_range(0, 31));
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_flush = 1'b0;
    s_vld   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      s_tag[i] = '0;
      s_val[i] = '0;
      s_rob[i] = '0;
    end
    drive();
    model_reset();
    @(negedge clk);
    step(1'b1, 1'b0, '0);

    // single result on channel 0
    s_tag[0] = 6'd5; s_val[0] = 64'h1234; s_rob[0] = 5'd3;
    step(1'b0, 1'b0, 4'b0001);
    step(1'b0, 1'b0, 4'b0000);
    chk("single vld",   64'(bus1.cdb_vld_o),     64'd1);
    chk("single wr_en", 64'(bus1.cdb_wr_en_o),   64'd1);
    chk("single tag",   64'(bus1.cdb_tag_o),     64'd5);
    chk("single value", bus1.cdb_value_o,        64'h1234);
    chk("single rob",   64'(bus1.cdb_rob_idx_o), 64'd3);
    step(1'b0, 1'b0, 4'b0000);
    chk("single gone", 64'(bus1.cdb_vld_o), 64'd0);

    // collision fairness, twice, from rr_ptr = 0
    step(1'b1, 1'b0, '0);
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        s_tag[i] = PRF_IDX_W'(10 + 10 * rep + i);
        s_val[i] = 64'(i);
        s_rob[i] = ROB_IDX_W'(i);
      end
      step(1'b0, 1'b0, 4'b1111);
      for (int i = 0; i < NUM_FU; i++) begin
        step(1'b0, 1'b0, 4'b0000);
        chk("fair order", 64'(bus1.cdb_tag_o), 64'(10 + 10 * rep + i));
      end
    end

    // full / overflow
    step(1'b1, 1'b0, '0);
    rand_payload();
    step(1'b0, 1'b0, 4'b1111);
    step(1'b0, 1'b0, 4'b1111);
    chk("ch1 full", 64'(bus1.fu_rdy_o[1]), 64'd0);
    for (int c = 0; c < 4; c++) begin
      rand_payload();
      step(1'b0, 1'b0, 4'b1111);
    end
    chk("overflow set", 64'(bus1.overflow_o), 64'd1);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 4'b0000);

    // dual CDB
    step(1'b1, 1'b0, '0);
    s_tag[1] = 6'd7; s_tag[3] = 6'd9;
    step(1'b0, 1'b0, 4'b1010);
    step(1'b0, 1'b0, 4'b0000);
    chk("dual vld",   64'(bus2.cdb_vld_o),       64'd3);
    chk("dual tag0",  64'(bus2.cdb_tag_o[5:0]),  64'd7);
    chk("dual tag1",  64'(bus2.cdb_tag_o[11:6]), 64'd9);
    step(1'b0, 1'b0, 4'b0000);

    // ZERO_TAG broadcast
    step(1'b1, 1'b0, '0);
    s_tag[2] = PRF_IDX_W'(ZERO_TAG);
    step(1'b0, 1'b0, 4'b0100);
    step(1'b0, 1'b0, 4'b0000);
    chk("zero vld",   64'(bus1.cdb_vld_o),   64'd1);
    chk("zero wr_en", 64'(bus1.cdb_wr_en_o), 64'd0);

    // flush with entries queued and a same-cycle push
    step(1'b1, 1'b0, '0);
    rand_payload();
    step(1'b0, 1'b0, 4'b0111);
    step(1'b0, 1'b1, 4'b1000);
    chk("flush c1 vld", 64'(bus1.cdb_vld_o), 64'd0);
    chk("flush c2 vld", 64'(bus2.cdb_vld_o), 64'd0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 4'b0000);

    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 2000; c++) begin
      rand_payload();
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 24) == 0),
           NUM_FU'($urandom_range(0, 15) & $urandom_range(0, 15)));
    end
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
